// File: rtl/pwr_subckt_toggle_mon.sv
// pwr_subckt_toggle_mon
//
// Pipelined evaluator for the power-experiment sub-circuit
//   f = d | (~a & b & c)   (mode = 0)
//   f = d ^ (~a & b & c)   (mode = 1)
// replicated over CH channels. Each channel counts output toggles over a
// window of WIN accepted samples. At every window end the counts are
// snapshotted into a report that is handed to the collector over a
// valid/ready port.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid                input sample strobe (no backpressure)
//   in_a/in_b/in_c/in_d     per-channel inputs, bit i = channel i
//   mode                    function select, sampled with the data
//   f_out, f_valid          registered function outputs and their strobe
//   rpt_valid, rpt_ready    report handshake
//   rpt_toggles             channel i count in [i*CNT_W +: CNT_W]
//   rpt_ovf                 channel counter saturated in the reported window
//   rpt_lost                sticky: a report was dropped because the previous
//                           one had not yet been taken

module pwr_subckt_toggle_mon #(
    parameter int          CH    = 4,
    parameter int          CNT_W = 16,
    parameter int unsigned WIN   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [CH-1:0]       in_a,
    input  logic [CH-1:0]       in_b,
    input  logic [CH-1:0]       in_c,
    input  logic [CH-1:0]       in_d,
    input  logic                mode,
    output logic [CH-1:0]       f_out,
    output logic                f_valid,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [CH*CNT_W-1:0] rpt_toggles,
    output logic [CH-1:0]       rpt_ovf,
    output logic                rpt_lost
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      LAST_IDX = 32'(WIN - 1);

    // Stage 1 registers
    logic [CH-1:0] s1_a, s1_b, s1_c, s1_d;
    logic          s1_mode;
    logic          s1_valid;

    // Stage 2 / toggle tracking
    logic [CH-1:0] f_prev;
    logic          prev_ok;

    // Window state
    logic [CNT_W-1:0] cnt [CH];
    logic [CH-1:0]    ovf;
    logic [31:0]      sample_cnt;

    // Combinational next values
    logic [CH-1:0]        f_nxt;
    logic [CH-1:0]        term;
    logic [CH-1:0]        tog;
    logic [CNT_W-1:0]     cnt_inc [CH];
    logic [CH-1:0]        ovf_inc;
    logic [CH*CNT_W-1:0]  snap;
    logic                 win_end;
    logic                 rpt_load;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        term     = ~s1_a & s1_b & s1_c;
        f_nxt    = s1_mode ? (s1_d ^ term) : (s1_d | term);
        tog      = '0;
        ovf_inc  = ovf;
        snap     = '0;
        if (f_valid && prev_ok) begin
            tog = f_out ^ f_prev;
        end
        for (int i = 0; i < CH; i++) begin
            cnt_inc[i] = cnt[i];
            if (tog[i]) begin
                // A toggle on a full counter holds the count and flags overflow.
                if (cnt[i] == CNT_MAX) begin
                    ovf_inc[i] = 1'b1;
                end else begin
                    cnt_inc[i] = cnt[i] + CNT_W'(1);
                end
            end
            snap[i*CNT_W +: CNT_W] = cnt_inc[i];
        end
        win_end  = f_valid && (sample_cnt == LAST_IDX);
        // A finished window may load only if the report slot is free or is
        // being emptied in this very cycle.
        rpt_load = win_end && (!rpt_valid || rpt_ready);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its sources (f_prev takes the
    // old f_out, not the new one).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_a        <= '0;
            s1_b        <= '0;
            s1_c        <= '0;
            s1_d        <= '0;
            s1_mode     <= 1'b0;
            s1_valid    <= 1'b0;
            f_out       <= '0;
            f_prev      <= '0;
            f_valid     <= 1'b0;
            prev_ok     <= 1'b0;
            // NOTE: the counter array is state visible in the report, so it is
            // reset like any other register rather than treated as RAM.
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
            ovf         <= '0;
            sample_cnt  <= '0;
            rpt_valid   <= 1'b0;
            rpt_toggles <= '0;
            rpt_ovf     <= '0;
            rpt_lost    <= 1'b0;
        end else begin
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_c    <= in_c;
                s1_d    <= in_d;
                s1_mode <= mode;
            end
            s1_valid <= in_valid;

            if (s1_valid) begin
                f_out  <= f_nxt;
                f_prev <= f_out;
            end
            f_valid <= s1_valid;

            if (f_valid) begin
                prev_ok <= 1'b1;
            end

            // The boundary sample's toggles go into the snapshot; the next
            // window starts from zero. f_prev/prev_ok persist so a toggle
            // across the boundary lands in the new window.
            if (win_end) begin
                for (int i = 0; i < CH; i++) begin
                    cnt[i] <= '0;
                end
                ovf        <= '0;
                sample_cnt <= '0;
            end else if (f_valid) begin
                cnt        <= cnt_inc;
                ovf        <= ovf_inc;
                sample_cnt <= sample_cnt + 32'd1;
            end

            if (rpt_load) begin
                rpt_valid   <= 1'b1;
                rpt_toggles <= snap;
                rpt_ovf     <= ovf_inc;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end

            if (win_end && !rpt_load) begin
                rpt_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwr_subckt_toggle_mon.sv
// Testbench for pwr_subckt_toggle_mon.
// Main instance: CH=4, CNT_W=16, WIN=8. Second instance: CH=4, CNT_W=3,
// WIN=16 for counter saturation. Both share the same stimulus.

module tb_pwr_subckt_toggle_mon;

    localparam int CH      = 4;
    localparam int CNT_W   = 16;
    localparam int WIN     = 8;
    localparam int S_CNT_W = 3;
    localparam int S_WIN   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [CH-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic          mode = 1'b0;
    logic          rpt_ready = 1'b0;

    logic [CH-1:0]          f_out;
    logic                   f_valid;
    logic                   rpt_valid;
    logic [CH*CNT_W-1:0]    rpt_toggles;
    logic [CH-1:0]          rpt_ovf;
    logic                   rpt_lost;

    logic [CH-1:0]          s_f_out;
    logic                   s_f_valid;
    logic                   s_rpt_valid;
    logic [CH*S_CNT_W-1:0]  s_rpt_toggles;
    logic [CH-1:0]          s_rpt_ovf;
    logic                   s_rpt_lost;

    pwr_subckt_toggle_mon #(.CH(CH), .CNT_W(CNT_W), .WIN(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .mode(mode),
        .f_out(f_out), .f_valid(f_valid),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_toggles(rpt_toggles), .rpt_ovf(rpt_ovf), .rpt_lost(rpt_lost)
    );

    pwr_subckt_toggle_mon #(.CH(CH), .CNT_W(S_CNT_W), .WIN(S_WIN)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .mode(mode),
        .f_out(s_f_out), .f_valid(s_f_valid),
        .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_toggles(s_rpt_toggles), .rpt_ovf(s_rpt_ovf), .rpt_lost(s_rpt_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int  n_vec = 0;
    int  n_bad = 0;
    bit  rpt_seen;

    typedef struct {
        logic [CH-1:0] a, b, c, d;
        logic          m;
        logic [CH-1:0] f;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic logic [63:0] pks(input int c0, input int c1, input int c2, input int c3);
        return 64'({3'(c3), 3'(c2), 3'(c1), 3'(c0)});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rpt_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One sample with a=b=c=0, mode=0, so f = d.
    task automatic send(input logic [CH-1:0] d);
        @(negedge clk);
        in_a = '0; in_b = '0; in_c = '0; in_d = d; mode = 1'b0;
        in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (rpt_valid) rpt_seen = 1'b1;
        end
    endtask

    // Wait (bounded) for a report from the main (sat=0) or saturation instance.
    task automatic wait_rpt(input string name, input bit sat,
                            output logic [63:0] tog, output logic [CH-1:0] ovf);
        bit got = 1'b0;
        tog = 'x;
        ovf = 'x;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (sat ? s_rpt_valid : rpt_valid) begin
                got = 1'b1;
                tog = sat ? 64'(s_rpt_toggles) : rpt_toggles;
                ovf = sat ? s_rpt_ovf : rpt_ovf;
            end
        end
        check({name, "_arrived"}, 64'(got), 64'd1);
    endtask

    // Two back-to-back windows: w1 ch0 alternating (7 toggles); w2 ch0 constant
    // 1 (1 boundary toggle), ch1 alternating from 0 (8 toggles).
    task automatic send_two_windows();
        for (int i = 0; i < 8; i++) send({3'b000, 1'(i % 2 == 0)});
        for (int i = 0; i < 8; i++) send({2'b00, 1'(i % 2 == 0), 1'b1});
    endtask

    logic [63:0]   tog;
    logic [CH-1:0] ovf;

    initial begin
        // a, b, c, d, mode, expected f
        vecs[0] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001};
        vecs[2] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000};
        vecs[3] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1111};
        vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000};
        vecs[5] = '{4'b0101, 4'b1111, 4'b0011, 4'b1010, 1'b0, 4'b1010};
        vecs[6] = '{4'b0101, 4'b1111, 4'b0011, 4'b1010, 1'b1, 4'b1000};
        vecs[7] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0000};
        vecs[8] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b1111};
        vecs[9] = '{4'b1010, 4'b0110, 4'b1100, 4'b0000, 1'b1, 4'b0100};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_f_out", 64'(f_out), 64'd0);
        check("rst_f_valid", 64'(f_valid), 64'd0);
        check("rst_rpt_valid", 64'(rpt_valid), 64'd0);
        check("rst_rpt_toggles", rpt_toggles, 64'd0);
        check("rst_rpt_lost", 64'(rpt_lost), 64'd0);
        rst_n = 1'b1;

        // Function table with exact two-cycle latency
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            in_a = vecs[v].a; in_b = vecs[v].b; in_c = vecs[v].c; in_d = vecs[v].d;
            mode = vecs[v].m; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_f_valid", v), 64'(f_valid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_f_valid", v), 64'(f_valid), 64'd1);
            check($sformatf("vec%0d_f_out", v), 64'(f_out), 64'(vecs[v].f));
        end

        // Two windows of alternating ch0, constant ch1
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < 8; i++) send({2'b00, 1'b1, 1'(i % 2 == 0)});
        wait_rpt("win1", 1'b0, tog, ovf);
        check("win1_toggles", tog, pk(7, 0, 0, 0));
        check("win1_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        check("win1_drop", 64'(rpt_valid), 64'd0);
        for (int i = 0; i < 8; i++) send({2'b00, 1'b1, 1'(i % 2 == 0)});
        wait_rpt("win2", 1'b0, tog, ovf);
        check("win2_toggles", tog, pk(8, 0, 0, 0));

        // Saturation on the narrow-counter instance
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < 16; i++) send({3'b000, 1'(i % 2 == 0)});
        wait_rpt("sat1", 1'b1, tog, ovf);
        check("sat1_toggles", tog, pks(7, 0, 0, 0));
        check("sat1_ovf", 64'(ovf), 64'b0001);
        for (int i = 0; i < 16; i++) send({3'b000, 1'(!(i == 2 || i == 3))});
        wait_rpt("sat2", 1'b1, tog, ovf);
        check("sat2_toggles", tog, pks(3, 0, 0, 0));
        check("sat2_ovf", 64'(ovf), 64'd0);

        // Collision with rpt_ready held low: first report kept, loss flagged
        do_reset();
        send_two_windows();
        idle(4);
        check("coll_valid", 64'(rpt_valid), 64'd1);
        check("coll_held_toggles", rpt_toggles, pk(7, 0, 0, 0));
        check("coll_lost", 64'(rpt_lost), 64'd1);
        @(negedge clk);
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        check("coll_release_drop", 64'(rpt_valid), 64'd0);

        // Collision with rpt_ready high exactly in the collision cycle
        do_reset();
        send_two_windows();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("coll2_first_valid", 64'(rpt_valid), 64'd1);
        check("coll2_first_toggles", rpt_toggles, pk(7, 0, 0, 0));
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        check("coll2_valid", 64'(rpt_valid), 64'd1);
        check("coll2_second_toggles", rpt_toggles, pk(1, 8, 0, 0));
        check("coll2_lost", 64'(rpt_lost), 64'd0);

        // Gapped input: window closes after 8 accepted samples, not 8 cycles
        do_reset();
        rpt_ready = 1'b1;
        rpt_seen  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send({3'b000, 1'(i % 2 == 0)});
            idle(1);
        end
        idle(4);
        check("gap_no_early_rpt", 64'(rpt_seen), 64'd0);
        send(4'b0000);
        wait_rpt("gap", 1'b0, tog, ovf);
        check("gap_toggles", tog, pk(7, 0, 0, 0));

        // Reset mid-window with a pending report and a sticky loss
        do_reset();
        send_two_windows();
        for (int i = 0; i < 5; i++) send(4'b0101);
        idle(3);
        check("prerst_valid", 64'(rpt_valid), 64'd1);
        check("prerst_lost", 64'(rpt_lost), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_f_out", 64'(f_out), 64'd0);
        check("rst2_f_valid", 64'(f_valid), 64'd0);
        check("rst2_rpt_valid", 64'(rpt_valid), 64'd0);
        check("rst2_rpt_toggles", rpt_toggles, 64'd0);
        check("rst2_rpt_ovf", 64'(rpt_ovf), 64'd0);
        check("rst2_rpt_lost", 64'(rpt_lost), 64'd0);
        rpt_ready = 1'b1;
        for (int i = 0; i < 8; i++) send({3'b000, 1'(i % 2 == 0)});
        wait_rpt("postrst", 1'b0, tog, ovf);
        check("postrst_toggles", tog, pk(7, 0, 0, 0));
        check("postrst_lost", 64'(rpt_lost), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
